// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the three-requester Wishbone arbiter.
// DRAIN state exists only when WB_ARB_TIMEOUT_EN is defined.
package wb_arbiter_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned SW   = 4;
  localparam int unsigned NREQ = 3;
  localparam int unsigned CNTW = 8;

  localparam logic [1:0] GNT_M0   = 2'd0;
  localparam logic [1:0] GNT_M1   = 2'd1;
  localparam logic [1:0] GNT_M2   = 2'd2;
  localparam logic [1:0] GNT_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1
`ifdef WB_ARB_TIMEOUT_EN
    ,
    ST_DRAIN   = 2'd2
`endif
  } arb_state_e;

  typedef struct packed {
    logic          cyc;
    logic [SW-1:0] stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wb_req_t;

  // Next requester index in circular order; anything past m2 wraps to m0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= GNT_M2) ? GNT_M0 : 2'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/wb_arbiter_arb_pick.sv
// Combinational 3-way winner selection: fixed priority m0>m1>m2, or
// round-robin starting at the requester after the last granted one.
module arb_pick
  import wb_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_last,
  input  logic            i_round_robin,
  output logic [1:0]      o_win,
  output logic            o_valid
);

  logic [1:0] idx;

  always_comb begin
    o_win   = GNT_NONE;
    o_valid = 1'b0;
    idx     = i_round_robin ? rr_next(i_last) : GNT_M0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!o_valid && i_req[idx]) begin
        o_win   = idx;
        o_valid = 1'b1;
      end
      idx = rr_next(idx);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Shares one Wishbone master port between fetcher (m0), load (m1) and store (m2).
// Optional watchdog with DRAIN state is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_m0_cyc,
  input  logic [SW-1:0] i_m0_stb,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_dat,
  input  logic          i_m1_cyc,
  input  logic [SW-1:0] i_m1_stb,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_dat,
  input  logic          i_m2_cyc,
  input  logic [SW-1:0] i_m2_stb,
  input  logic          i_m2_we,
  input  logic [AW-1:0] i_m2_addr,
  input  logic [DW-1:0] i_m2_dat,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic          o_m2_ack,
  output logic          o_m2_err,
  output logic [DW-1:0] o_m_dat,
  output logic          o_wb_cyc,
  output logic [SW-1:0] o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_dat,
  input  logic [DW-1:0] i_wb_dat,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  output logic [1:0]    o_grant
);

  arb_state_e      state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  wb_req_t         req [NREQ];
  wb_req_t         sel;
  logic [NREQ-1:0] req_vec;
  logic [1:0]      pick_win;
  logic            pick_valid;
  logic            bus_en;
  logic            route_en;
  logic            to_err;
  logic            ack_ok;
  logic            err_ok;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT - 1);
  logic [CNTW-1:0] cnt_q, cnt_d;
`endif

  assign req[0] = '{cyc: i_m0_cyc, stb: i_m0_stb, we: i_m0_we, addr: i_m0_addr, dat: i_m0_dat};
  assign req[1] = '{cyc: i_m1_cyc, stb: i_m1_stb, we: i_m1_we, addr: i_m1_addr, dat: i_m1_dat};
  assign req[2] = '{cyc: i_m2_cyc, stb: i_m2_stb, we: i_m2_we, addr: i_m2_addr, dat: i_m2_dat};
  assign req_vec = {i_m2_cyc, i_m1_cyc, i_m0_cyc};

  arb_pick u_pick (
    .i_req         (req_vec),
    .i_last        (last_q),
    .i_round_robin (ROUND_ROBIN),
    .o_win         (pick_win),
    .o_valid       (pick_valid)
  );

  // Payload of the currently granted requester.
  always_comb begin
    sel = '0;
    case (grant_q)
      GNT_M0:  sel = req[0];
      GNT_M1:  sel = req[1];
      GNT_M2:  sel = req[2];
      default: sel = '0;
    endcase
  end

  // Next-state, grant bookkeeping and bus enables.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    bus_en   = 1'b0;
    route_en = 1'b0;
    to_err   = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANTED;
          grant_d = pick_win;
`ifdef WB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANTED: begin
        route_en = 1'b1;
        if (!sel.cyc) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
          last_d  = grant_q;
        end else begin
          bus_en = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
          if (i_wb_ack || i_wb_err) begin
            cnt_d = '0;
          end else if (cnt_q == TO_LAST) begin
            to_err  = 1'b1;
            bus_en  = 1'b0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = CNTW'(cnt_q + 1'b1);
          end
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      // Bus stays idle; late slave responses are dropped until the requester lets go.
      ST_DRAIN: begin
        if (!sel.cyc) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
          last_d  = grant_q;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // Bus mux and response routing; err takes precedence over ack.
  always_comb begin
    o_wb_cyc  = bus_en;
    o_wb_stb  = bus_en ? sel.stb  : '0;
    o_wb_we   = bus_en ? sel.we   : 1'b0;
    o_wb_addr = bus_en ? sel.addr : '0;
    o_wb_dat  = bus_en ? sel.dat  : '0;
    ack_ok    = route_en & i_wb_ack & ~i_wb_err;
    err_ok    = (route_en & i_wb_err) | to_err;
    o_m0_ack  = ack_ok & (grant_q == GNT_M0);
    o_m1_ack  = ack_ok & (grant_q == GNT_M1);
    o_m2_ack  = ack_ok & (grant_q == GNT_M2);
    o_m0_err  = err_ok & (grant_q == GNT_M0);
    o_m1_err  = err_ok & (grant_q == GNT_M1);
    o_m2_err  = err_ok & (grant_q == GNT_M2);
  end

  assign o_m_dat = i_wb_dat;
  assign o_grant = grant_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_NONE;
      last_q  <= GNT_M2;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one fixed-priority and one round-robin instance
// share stimulus; the watchdog scenario runs when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cyc;
  logic [3:0]  stb   [3];
  logic [2:0]  we;
  logic [31:0] addr  [3];
  logic [31:0] wdat  [3];
  logic [31:0] wb_rdat;
  logic        wb_ack;
  logic        wb_err;

  logic [2:0]  fp_ack, fp_err, rr_ack, rr_err;
  logic [31:0] fp_mdat, rr_mdat;
  logic        fp_wb_cyc, rr_wb_cyc;
  logic [3:0]  fp_wb_stb, rr_wb_stb;
  logic        fp_wb_we, rr_wb_we;
  logic [31:0] fp_wb_addr, rr_wb_addr, fp_wb_dat, rr_wb_dat;
  logic [1:0]  fp_grant, rr_grant;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .ROUND_ROBIN(1'b0)
`ifdef WB_ARB_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) u_fp (
    .i_clk(clk), .i_reset(rst),
    .i_m0_cyc(cyc[0]), .i_m0_stb(stb[0]), .i_m0_we(we[0]), .i_m0_addr(addr[0]), .i_m0_dat(wdat[0]),
    .i_m1_cyc(cyc[1]), .i_m1_stb(stb[1]), .i_m1_we(we[1]), .i_m1_addr(addr[1]), .i_m1_dat(wdat[1]),
    .i_m2_cyc(cyc[2]), .i_m2_stb(stb[2]), .i_m2_we(we[2]), .i_m2_addr(addr[2]), .i_m2_dat(wdat[2]),
    .o_m0_ack(fp_ack[0]), .o_m0_err(fp_err[0]),
    .o_m1_ack(fp_ack[1]), .o_m1_err(fp_err[1]),
    .o_m2_ack(fp_ack[2]), .o_m2_err(fp_err[2]),
    .o_m_dat(fp_mdat),
    .o_wb_cyc(fp_wb_cyc), .o_wb_stb(fp_wb_stb), .o_wb_we(fp_wb_we),
    .o_wb_addr(fp_wb_addr), .o_wb_dat(fp_wb_dat),
    .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .o_grant(fp_grant)
  );

  wb_arbiter #(
    .ROUND_ROBIN(1'b1)
`ifdef WB_ARB_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) u_rr (
    .i_clk(clk), .i_reset(rst),
    .i_m0_cyc(cyc[0]), .i_m0_stb(stb[0]), .i_m0_we(we[0]), .i_m0_addr(addr[0]), .i_m0_dat(wdat[0]),
    .i_m1_cyc(cyc[1]), .i_m1_stb(stb[1]), .i_m1_we(we[1]), .i_m1_addr(addr[1]), .i_m1_dat(wdat[1]),
    .i_m2_cyc(cyc[2]), .i_m2_stb(stb[2]), .i_m2_we(we[2]), .i_m2_addr(addr[2]), .i_m2_dat(wdat[2]),
    .o_m0_ack(rr_ack[0]), .o_m0_err(rr_err[0]),
    .o_m1_ack(rr_ack[1]), .o_m1_err(rr_err[1]),
    .o_m2_ack(rr_ack[2]), .o_m2_err(rr_err[2]),
    .o_m_dat(rr_mdat),
    .o_wb_cyc(rr_wb_cyc), .o_wb_stb(rr_wb_stb), .o_wb_we(rr_wb_we),
    .o_wb_addr(rr_wb_addr), .o_wb_dat(rr_wb_dat),
    .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .o_grant(rr_grant)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Hand-derived round-robin order and the bus payload each winner presents.
  int unsigned rr_seq   [4] = '{0, 1, 2, 0};
  logic [31:0] exp_addr [3] = '{32'h100, 32'h200, 32'h300};
  logic [4:0]  exp_sw   [3] = '{5'b0001_0, 5'b1111_1, 5'b0011_0};
  logic [31:0] exp_dat  [3] = '{32'h0000_00A0, 32'h1111_2222, 32'h0000_0033};

  initial begin
    rst     = 1'b1;
    cyc     = 3'b000;
    we      = 3'b010;
    wb_ack  = 1'b0;
    wb_err  = 1'b0;
    wb_rdat = 32'h0;
    stb[0]  = 4'h1; addr[0] = 32'h100; wdat[0] = 32'h0000_00A0;
    stb[1]  = 4'hF; addr[1] = 32'h200; wdat[1] = 32'h1111_2222;
    stb[2]  = 4'h3; addr[2] = 32'h300; wdat[2] = 32'h0000_0033;

    // Requests held during reset must not reach the bus.
    cyc = 3'b011;
    tick();
    tick();
    check_eq("rst_grant", 32'(fp_grant), 32'd3);
    check_eq("rst_cyc", 32'(fp_wb_cyc), 32'd0);
    check_eq("rst_addr", fp_wb_addr, 32'h0);
    rst = 1'b0;
    tick();
    check_eq("first_grant_fp", 32'(fp_grant), 32'd0);
    check_eq("first_grant_rr", 32'(rr_grant), 32'd0);
    check_eq("first_cyc", 32'(fp_wb_cyc), 32'd1);
    check_eq("first_addr", fp_wb_addr, 32'h100);
    wb_ack  = 1'b1;
    wb_rdat = 32'hDEAD_BEEF;
    settle();
    check_eq("m0_ack_route", 32'(fp_ack), 32'b001);
    check_eq("rdat_fp", fp_mdat, 32'hDEAD_BEEF);
    check_eq("rdat_rr", rr_mdat, 32'hDEAD_BEEF);
    wb_ack = 1'b0;
    cyc    = 3'b000;
    settle();
    check_eq("drop_cyc_comb", 32'(fp_wb_cyc), 32'd0);
    tick();
    check_eq("idle_after_m0", 32'(fp_grant), 32'd3);

    // Fixed priority: m1 beats m2, then m2 after one idle cycle.
    cyc = 3'b110;
    tick();
    check_eq("fp_m1_grant", 32'(fp_grant), 32'd1);
    check_eq("fp_m1_addr", fp_wb_addr, 32'h200);
    check_eq("fp_m1_we", 32'(fp_wb_we), 32'd1);
    check_eq("fp_m1_dat", fp_wb_dat, 32'h1111_2222);
    wb_ack = 1'b1;
    settle();
    check_eq("fp_m1_ack_only", 32'(fp_ack), 32'b010);
    wb_ack = 1'b0;
    cyc[1] = 1'b0;
    settle();
    check_eq("fp_m1_drop", 32'(fp_wb_cyc), 32'd0);
    tick();
    check_eq("fp_idle_gap", 32'(fp_grant), 32'd3);
    check_eq("fp_idle_cyc", 32'(fp_wb_cyc), 32'd0);
    tick();
    check_eq("fp_m2_grant", 32'(fp_grant), 32'd2);
    check_eq("fp_m2_addr", fp_wb_addr, 32'h300);
    check_eq("fp_m2_stb", 32'(fp_wb_stb), 32'h3);

    // err and ack together: err wins, only m2 sees it.
    wb_ack = 1'b1;
    wb_err = 1'b1;
    settle();
    check_eq("both_err", 32'(fp_err), 32'b100);
    check_eq("both_ack", 32'(fp_ack), 32'b000);
    wb_ack = 1'b0;
    wb_err = 1'b0;
    cyc    = 3'b000;
    tick();
    check_eq("idle_after_m2", 32'(fp_grant), 32'd3);

    // Round-robin with all three requesting: 0,1,2,0.
    cyc = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rr_grant", 32'(rr_grant), 32'(rr_seq[i]));
      check_eq("rr_addr", rr_wb_addr, exp_addr[rr_seq[i]]);
      check_eq("rr_stb_we", 32'({rr_wb_stb, rr_wb_we}), 32'(exp_sw[rr_seq[i]]));
      check_eq("rr_dat", rr_wb_dat, exp_dat[rr_seq[i]]);
      wb_ack = 1'b1;
      settle();
      check_eq("rr_ack", 32'(rr_ack), 32'(3'b001 << rr_seq[i]));
      wb_ack = 1'b0;
      cyc[rr_seq[i]] = 1'b0;
      tick();
      check_eq("rr_idle", 32'(rr_grant), 32'd3);
      cyc[rr_seq[i]] = 1'b1;
    end
    cyc = 3'b000;
    tick();
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: 4 unanswered cycles -> single err pulse, bus drops, grant held.
    cyc = 3'b010;
    tick();
    check_eq("to_grant", 32'(fp_grant), 32'd1);
    for (int w = 1; w <= 3; w++) begin
      check_eq("to_wait_err", 32'(fp_err), 32'b000);
      check_eq("to_wait_cyc", 32'(fp_wb_cyc), 32'd1);
      tick();
    end
    check_eq("to_pulse_err", 32'(fp_err), 32'b010);
    check_eq("to_pulse_cyc", 32'(fp_wb_cyc), 32'd0);
    tick();
    check_eq("drain_err", 32'(fp_err), 32'b000);
    check_eq("drain_cyc", 32'(fp_wb_cyc), 32'd0);
    check_eq("drain_grant", 32'(fp_grant), 32'd1);
    wb_ack = 1'b1;
    settle();
    check_eq("drain_ack_ignored", 32'(fp_ack), 32'b000);
    wb_ack = 1'b0;
    tick();
    check_eq("drain_no_repulse", 32'(fp_err), 32'b000);
    cyc = 3'b000;
    tick();
    check_eq("drain_release", 32'(fp_grant), 32'd3);
`endif

    // Reset during an active m0 transfer.
    cyc = 3'b001;
    tick();
    check_eq("pre_rst_grant", 32'(fp_grant), 32'd0);
    rst    = 1'b1;
    wb_ack = 1'b1;
    tick();
    check_eq("midrst_grant", 32'(fp_grant), 32'd3);
    check_eq("midrst_cyc", 32'(fp_wb_cyc), 32'd0);
    check_eq("midrst_ack", 32'(fp_ack), 32'b000);
    check_eq("midrst_rr_cyc", 32'(rr_wb_cyc), 32'd0);
    check_eq("midrst_rr_resp", 32'({rr_ack, rr_err}), 32'd0);
    rst    = 1'b0;
    wb_ack = 1'b0;
    cyc    = 3'b000;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single CPU Wishbone master port between three requesters: fetcher (m0), load unit (m1) and store unit (m2).
- Replaces the ad-hoc cyc-based output muxing in the CPU top level.
- Grants one requester per bus cycle and holds the grant until that requester drops cyc.
- Routes ack/err only to the granted requester.

Parameters:
- ROUND_ROBIN, 0, 0 = fixed priority m0>m1>m2; 1 = round-robin, search starts at the requester after the last granted one.
- TIMEOUT, 255, watchdog limit in cycles (8-bit counter); used only with WB_ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_mN_cyc  in  1  requester N bus request/cycle (N=0,1,2)
- i_mN_stb  in  4  requester N byte strobes
- i_mN_we  in  1  requester N write enable
- i_mN_addr  in  32  requester N address
- i_mN_dat  in  32  requester N write data
- o_mN_ack  out  1  ack routed to requester N
- o_mN_err  out  1  err routed to requester N
- o_m_dat  out  32  read data, broadcast to all requesters (= i_wb_dat)
- o_wb_cyc  out  1  shared bus cyc
- o_wb_stb  out  4  shared bus strobes
- o_wb_we  out  1  shared bus write enable
- o_wb_addr  out  32  shared bus address
- o_wb_dat  out  32  shared bus write data
- i_wb_dat  in  32  bus read data
- i_wb_ack  in  1  bus ack
- i_wb_err  in  1  bus err
- o_grant  out  2  current grant: 0/1/2 = mN, 3 = none

Behaviour:
- States: IDLE, GRANTED, DRAIN (DRAIN exists only with WB_ARB_TIMEOUT_EN).
- Reset:
  - state=IDLE, o_grant=3, last-grant pointer=2 (so round-robin starts at m0).
  - All o_wb_* = 0; all o_mN_ack/err = 0.
  - Reset mid-transfer drops o_wb_cyc on the next edge, unconditionally.
- IDLE:
  - If any i_mN_cyc=1, select a winner per ROUND_ROBIN, register the grant and go to GRANTED.
  - Arbitration latency: request seen at edge n; bus driven from cycle n+1.
- GRANTED:
  - o_wb_* driven combinationally from the granted requester's inputs, so stb/addr/dat may change per beat.
  - o_mN_ack = i_wb_ack & (grant==N); o_mN_err = i_wb_err & (grant==N).
  - When both ack and err are high in one cycle, err wins and ack is suppressed.
  - When the granted i_mN_cyc drops:
    - o_wb_cyc is low that same cycle (combinational follow).
    - Next state is IDLE.
    - The last-grant pointer updates to N.
  - Minimum one IDLE cycle between grants.
- Non-granted requesters:
  - See ack=err=0.
  - Their cyc may stay asserted indefinitely; they are served at a later IDLE arbitration.
- No grant: o_wb_cyc=0, o_wb_stb=0, o_wb_we=0, o_wb_addr=0, o_wb_dat=0.
- Round-robin fairness: with all three requesting continuously, grant order is 0,1,2,0,...
- Fixed-priority mode: m2 may starve; this is accepted.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Enabled:
  - 8-bit counter cleared on grant and on every i_wb_ack/i_wb_err.
  - Increments each GRANTED cycle with neither ack nor err.
  - When it reaches TIMEOUT: one-cycle o_mN_err pulse to the granted requester, o_wb_cyc forced 0, state goes to DRAIN.
  - DRAIN holds the grant with the bus idle until that requester drops cyc, then goes to IDLE.
  - Any i_wb_ack/err arriving in DRAIN is ignored.
- Disabled:
  - No counter and no DRAIN state.
  - GRANTED waits indefinitely.

Decomposition:
- defines.v gains `GNT_M0 / `GNT_M1 / `GNT_M2 / `GNT_NONE (2-bit) and arbiter state encodings.
- One sub-module, arb_pick:
  - Combinational 3-way selector.
  - Inputs: request vector, last grant, mode.
  - Output: winner index plus valid.

Test Plan:
- Reset with m0 and m1 cyc=1 → o_grant=3 and o_wb_cyc=0 during reset; first cycle after reset release o_grant=0, bus carries m0 addr 0x100.
- Fixed priority: m1 and m2 request together, ROUND_ROBIN=0 → m1 granted; m1 receives ack, m2 sees ack=0; after m1 drops cyc, one IDLE cycle, then m2 granted.
- Round-robin: all three hold cyc, each does one ack'd beat → grant sequence 0,1,2,0.
- Simultaneous i_wb_ack=1 and i_wb_err=1 while m2 granted → o_m2_err=1, o_m2_ack=0, others 0.
- WB_ARB_TIMEOUT_EN, TIMEOUT=4, m1 granted, slave never acks → o_m1_err pulses exactly once on the 4th wait cycle; o_wb_cyc=0 from that cycle; grant released after m1 drops cyc.
- Reset asserted mid-transfer with m0 granted → o_wb_cyc=0 and o_grant=3 on the next edge, no ack forwarded.
